// File: rtl/mmuart_fifo.sv
// mmuart_fifo: memory-mapped UART with RX/TX FIFOs, programmable baud tick,
// 16x oversampled engines, optional parity and sticky error flags.
module mmuart_fifo #(
   parameter int FIFO_LOG2   = 4,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 53
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic        rx,
   output logic        tx,
   input  logic [1:0]  addr,
   input  logic        write,
   input  logic        read,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);
   localparam int DEPTH = 2 ** FIFO_LOG2;
   typedef logic [FIFO_LOG2:0]   cnt_t;
   typedef logic [FIFO_LOG2-1:0] ptr_t;
   typedef logic [DIV_W-1:0]     div_t;
   localparam cnt_t FULL = cnt_t'(DEPTH);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

   div_t       div_reg, div_cnt;
   logic [3:0] ctrl;
   logic       tick;
   logic       bus_rd, bus_wr, cpu_pop, cpu_push;
   logic       overrun, frame_err, parity_err;
   logic       ov_set, fe_set, pe_set;
   logic [2:0] flag_clr;

   logic [7:0] rx_mem [DEPTH];
   ptr_t       rx_wp, rx_rp;
   cnt_t       rx_count;
   logic       rx_wr;
   logic [7:0] rx_wr_data;

   logic [7:0] tx_mem [DEPTH];
   ptr_t       tx_wp, tx_rp;
   cnt_t       tx_count;
   logic       tx_pop;

   rx_state_t  rx_state;
   logic       rx_s1, rx_s2, rx_prev;
   logic [3:0] rbcnt;
   logic [2:0] rbit;
   logic [7:0] rsh;
   logic       rpe, rpo, rpar;

   tx_state_t  tx_state;
   logic [3:0] tbcnt;
   logic [2:0] tbit;
   logic [7:0] tsh;
   logic       tpe, tpo;

   logic       tx_idle;
   logic [31:0] status;
   logic       unused_wdata;

   assign unused_wdata = ^wdata[31:DIV_W];

   assign tick     = (div_cnt == div_reg);
   assign bus_rd   = ce & read;
   assign bus_wr   = ce & write & ~read;
   assign cpu_pop  = bus_rd && (addr == 2'd0) && (rx_count != '0);
   assign cpu_push = bus_wr && (addr == 2'd0) && (tx_count != FULL);
   assign flag_clr = (bus_wr && addr == 2'd1) ? wdata[5:3] : 3'b000;
   assign tx_idle  = (tx_count == '0) && (tx_state == TX_IDLE);
   // A pop happens on a tick from IDLE, or at the end of a stop bit so frames run back-to-back.
   assign tx_pop   = tick && (tx_count != '0) &&
                     ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tbcnt == 4'd15));
   assign status   = {8'b0, 8'(tx_count), 8'(rx_count), 2'b0, parity_err, frame_err, overrun,
                      tx_idle, (tx_count != FULL), (rx_count != '0)};

   // Control registers and the baud tick divider.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_reg <= div_t'(DEFAULT_DIV);
         div_cnt <= '0;
         ctrl    <= '0;
      end else begin
         if (bus_wr && addr == 2'd2) ctrl <= wdata[3:0];
         if (bus_wr && addr == 2'd3) begin
            div_reg <= wdata[DIV_W-1:0];
            div_cnt <= '0;
         end else if (tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + div_t'(1);
         end
      end
   end

   // FIFO storage (no reset needed; validity comes from the counts).
   always_ff @(posedge clock) begin
      if (rx_wr) rx_mem[rx_wp] <= rx_wr_data;
      if (cpu_push) tx_mem[tx_wp] <= wdata[7:0];
   end

   // FIFO pointers and occupancy counts.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
         tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
      end else begin
         if (rx_wr)    rx_wp <= rx_wp + ptr_t'(1);
         if (cpu_pop)  rx_rp <= rx_rp + ptr_t'(1);
         rx_count <= rx_count + cnt_t'(rx_wr) - cnt_t'(cpu_pop);
         if (cpu_push) tx_wp <= tx_wp + ptr_t'(1);
         if (tx_pop)   tx_rp <= tx_rp + ptr_t'(1);
         tx_count <= tx_count + cnt_t'(cpu_push) - cnt_t'(tx_pop);
      end
   end

   // Registered read data, sticky flags and interrupt.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdata      <= '0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (bus_rd) begin
            case (addr)
               2'd0:    rdata <= (rx_count != '0) ? {24'b0, rx_mem[rx_rp]} : '0;
               2'd1:    rdata <= status;
               2'd2:    rdata <= {28'b0, ctrl};
               default: rdata <= {{(32-DIV_W){1'b0}}, div_reg};
            endcase
         end
         overrun    <= ov_set | (overrun    & ~flag_clr[0]);
         frame_err  <= fe_set | (frame_err  & ~flag_clr[1]);
         parity_err <= pe_set | (parity_err & ~flag_clr[2]);
         irq <= (ctrl[2] & (rx_count != '0)) | (ctrl[3] & tx_idle) |
                overrun | frame_err | parity_err;
      end
   end

   // RX synchroniser and receive FSM; bits sampled at oversample count 8.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
         rx_state <= RX_IDLE;
         rbcnt <= '0; rbit <= '0; rsh <= '0;
         rpe <= 1'b0; rpo <= 1'b0; rpar <= 1'b0;
         rx_wr <= 1'b0; rx_wr_data <= '0;
         ov_set <= 1'b0; fe_set <= 1'b0; pe_set <= 1'b0;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         rx_wr   <= 1'b0;
         ov_set  <= 1'b0;
         fe_set  <= 1'b0;
         pe_set  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state <= RX_START;
                  rbcnt    <= '0;
                  rpe      <= ctrl[0];
                  rpo      <= ctrl[1];
               end
            end
            RX_BREAK: begin
               if (rx_s2) rx_state <= RX_IDLE;
            end
            default: begin
               if (tick) begin
                  rbcnt <= rbcnt + 4'd1;
                  case (rx_state)
                     RX_START: begin
                        if (rbcnt == 4'd8 && rx_s2) begin
                           rx_state <= RX_IDLE;
                        end else if (rbcnt == 4'd15) begin
                           rx_state <= RX_DATA;
                           rbit     <= '0;
                        end
                     end
                     RX_DATA: begin
                        if (rbcnt == 4'd8) rsh <= {rx_s2, rsh[7:1]};
                        if (rbcnt == 4'd15) begin
                           if (rbit == 3'd7) rx_state <= rpe ? RX_PARITY : RX_STOP;
                           else              rbit     <= rbit + 3'd1;
                        end
                     end
                     RX_PARITY: begin
                        if (rbcnt == 4'd8)  rpar     <= rx_s2;
                        if (rbcnt == 4'd15) rx_state <= RX_STOP;
                     end
                     RX_STOP: begin
                        if (rbcnt == 4'd8) begin
                           if (!rx_s2) begin
                              fe_set   <= 1'b1;
                              rx_state <= RX_BREAK;
                           end else begin
                              rx_state <= RX_IDLE;
                              if (rpe && (rpar != (^rsh ^ rpo))) pe_set <= 1'b1;
                              else if (rx_count == FULL)          ov_set <= 1'b1;
                              else begin
                                 rx_wr      <= 1'b1;
                                 rx_wr_data <= rsh;
                              end
                           end
                        end
                     end
                     default: rx_state <= RX_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   // TX FSM; each bit lasts 16 ticks, tx is a registered output.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx <= 1'b1;
         tbcnt <= '0; tbit <= '0; tsh <= '0;
         tpe <= 1'b0; tpo <= 1'b0;
      end else if (tx_pop) begin
         tsh      <= tx_mem[tx_rp];
         tpe      <= ctrl[0];
         tpo      <= ctrl[1];
         tx_state <= TX_START;
         tbcnt    <= '0;
         tx       <= 1'b0;
      end else if (tick && tx_state != TX_IDLE) begin
         if (tbcnt != 4'd15) begin
            tbcnt <= tbcnt + 4'd1;
         end else begin
            tbcnt <= '0;
            case (tx_state)
               TX_START: begin
                  tx_state <= TX_DATA;
                  tbit     <= '0;
                  tx       <= tsh[0];
               end
               TX_DATA: begin
                  if (tbit == 3'd7) begin
                     if (tpe) begin
                        tx_state <= TX_PARITY;
                        tx       <= ^tsh ^ tpo;
                     end else begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                     end
                  end else begin
                     tbit <= tbit + 3'd1;
                     tx   <= tsh[3'(tbit + 3'd1)];
                  end
               end
               TX_PARITY: begin
                  tx_state <= TX_STOP;
                  tx       <= 1'b1;
               end
               default: begin
                  tx_state <= TX_IDLE;
                  tx       <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mmuart_fifo.sv
// tb_mmuart_fifo: scoreboard bench; stimulus queues expected values, a monitor
// pops and compares whenever a read result or a requested sample appears.
module tb_mmuart_fifo;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b0;
   logic        rx_w;
   logic        tx_w;
   logic [1:0]  addr = '0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq;

   logic        rx_drv = 1'b1;
   logic        loop = 1'b0;
   int          smp_kind = 0;   // 1 = tx, 2 = rdata, 3 = irq
   int          total = 0;
   int          bad = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } item_t;
   item_t q[$];

   assign rx_w = loop ? tx_w : rx_drv;

   mmuart_fifo #(.FIFO_LOG2(2), .DIV_W(16), .DEFAULT_DIV(53)) dut (
      .clock(clock), .reset(reset), .ce(ce), .rx(rx_w), .tx(tx_w),
      .addr(addr), .write(write), .read(read), .wdata(wdata),
      .rdata(rdata), .irq(irq)
   );

   always #5 clock = ~clock;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Monitor: captures strobes at the clock edge, compares on the falling edge.
   initial begin
      logic        m_rd;
      int          m_k;
      logic [31:0] act;
      item_t       it;
      forever begin
         @(posedge clock);
         m_rd = ce && read;
         m_k  = smp_kind;
         @(negedge clock);
         if (m_rd || m_k != 0) begin
            if (q.size() == 0) begin
               bad++;
               $display("FAIL scoreboard_empty: output seen with no expectation queued");
            end else begin
               it = q.pop_front();
               if (m_rd || m_k == 2) act = rdata;
               else if (m_k == 1)    act = {31'b0, tx_w};
               else                  act = {31'b0, irq};
               total++;
               if (act !== it.exp) begin
                  bad++;
                  $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(posedge clock); #1;
      ce = 1'b1; write = 1'b1; addr = a; wdata = d;
      @(posedge clock); #1;
      ce = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string nm);
      @(posedge clock); #1;
      ce = 1'b1; read = 1'b1; addr = a;
      q.push_back('{name: nm, exp: e});
      @(posedge clock); #1;
      ce = 1'b0; read = 1'b0;
   endtask

   task automatic sample(input int k, input logic [31:0] e, input string nm);
      @(posedge clock); #1;
      smp_kind = k;
      q.push_back('{name: nm, exp: e});
      @(posedge clock); #1;
      smp_kind = 0;
   endtask

   task automatic rx_bit(input logic v);
      @(posedge clock); #1;
      rx_drv = v;
      repeat (63) @(posedge clock);
   endtask

   // One frame at 64 clocks per bit, followed by one idle bit.
   task automatic send_rx(input logic [7:0] b, input logic pen, input logic pbit, input logic stopb);
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(b[i]);
      if (pen) rx_bit(pbit);
      rx_bit(stopb);
      rx_bit(1'b1);
   endtask

   initial begin
      logic [7:0] a5;
      a5 = 8'hA5;

      // Reset state
      cyc(4);
      @(posedge clock); #1 reset = 1'b0;
      sample(2, 32'h0, "rst_rdata");
      sample(1, 32'h1, "rst_tx");
      sample(3, 32'h0, "rst_irq");
      bus_read(2'd1, 32'h6, "rst_status");
      bus_read(2'd2, 32'h0, "rst_ctrl");
      bus_read(2'd3, 32'd53, "rst_div");
      bus_read(2'd0, 32'h0, "rst_rx_empty");

      // TX-idle interrupt enable
      bus_write(2'd2, 32'h8);
      sample(3, 32'h1, "irq_tx_idle");
      bus_write(2'd2, 32'h0);
      sample(3, 32'h0, "irq_off");

      // Single frame 0xA5 at DIV=3, sampled mid-bit
      bus_write(2'd3, 32'd3);
      bus_read(2'd3, 32'd3, "div_rb");
      bus_write(2'd0, 32'hA5);
      cyc(32);
      sample(1, 32'h0, "tx_start");
      for (int i = 0; i < 8; i++) begin
         cyc(62);
         sample(1, {31'b0, a5[i]}, $sformatf("tx_bit%0d", i));
      end
      cyc(62);
      sample(1, 32'h1, "tx_stop");
      cyc(40);
      bus_read(2'd1, 32'h6, "tx_done_status");

      // Loopback of three bytes
      loop = 1'b1;
      bus_write(2'd0, 32'h00);
      bus_write(2'd0, 32'hFF);
      bus_write(2'd0, 32'h3C);
      cyc(2100);
      bus_read(2'd1, 32'h307, "loop_status");
      bus_read(2'd0, 32'h00, "loop_rd0");
      bus_read(2'd0, 32'hFF, "loop_rd1");
      bus_read(2'd0, 32'h3C, "loop_rd2");
      loop = 1'b0;

      // RX overrun with a 4-deep FIFO
      send_rx(8'h11, 1'b0, 1'b0, 1'b1);
      send_rx(8'h22, 1'b0, 1'b0, 1'b1);
      send_rx(8'h33, 1'b0, 1'b0, 1'b1);
      send_rx(8'h44, 1'b0, 1'b0, 1'b1);
      send_rx(8'h55, 1'b0, 1'b0, 1'b1);
      bus_read(2'd1, 32'h40F, "ovr_status");
      sample(3, 32'h1, "ovr_irq");
      bus_write(2'd1, 32'h8);
      bus_read(2'd1, 32'h407, "ovr_cleared");
      sample(3, 32'h0, "ovr_irq_cleared");
      bus_read(2'd0, 32'h11, "ovr_rd0");
      bus_read(2'd0, 32'h22, "ovr_rd1");
      bus_read(2'd0, 32'h33, "ovr_rd2");
      bus_read(2'd0, 32'h44, "ovr_rd3");
      bus_read(2'd0, 32'h0, "ovr_rd_empty");

      // Even parity: 0x07 needs parity bit 1
      bus_write(2'd2, 32'h1);
      bus_read(2'd2, 32'h1, "ctrl_rb");
      send_rx(8'h07, 1'b1, 1'b0, 1'b1);
      bus_read(2'd1, 32'h26, "par_bad_status");
      bus_write(2'd1, 32'h20);
      send_rx(8'h07, 1'b1, 1'b1, 1'b1);
      bus_read(2'd1, 32'h107, "par_good_status");
      bus_read(2'd0, 32'h07, "par_good_rd");
      bus_write(2'd2, 32'h0);

      // Framing error, then a short glitch
      send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
      bus_read(2'd1, 32'h16, "frame_status");
      bus_write(2'd1, 32'h10);
      bus_read(2'd1, 32'h6, "frame_cleared");
      @(posedge clock); #1 rx_drv = 1'b0;
      cyc(4);
      #0 rx_drv = 1'b1;
      cyc(200);
      bus_read(2'd1, 32'h6, "glitch_status");

      // Five writes into a 4-deep TX FIFO with the tick held off
      bus_write(2'd3, 32'd200);
      bus_write(2'd0, 32'hC1);
      bus_write(2'd0, 32'hC2);
      bus_write(2'd0, 32'hC3);
      bus_write(2'd0, 32'hC4);
      bus_write(2'd0, 32'hC5);
      bus_read(2'd1, 32'h40000, "txfull_status");
      loop = 1'b1;
      bus_write(2'd3, 32'd3);
      cyc(2600);
      bus_read(2'd1, 32'h407, "b2b_status");
      bus_read(2'd0, 32'hC1, "b2b_rd0");
      bus_read(2'd0, 32'hC2, "b2b_rd1");
      bus_read(2'd0, 32'hC3, "b2b_rd2");
      bus_read(2'd0, 32'hC4, "b2b_rd3");
      bus_read(2'd0, 32'h0, "b2b_rd_empty");

      // Reset in the middle of a frame
      bus_write(2'd0, 32'h00);
      cyc(100);
      sample(1, 32'h0, "midframe_tx");
      @(posedge clock); #1;
      reset = 1'b1;
      smp_kind = 1;
      q.push_back('{name: "reset_tx", exp: 32'h1});
      @(posedge clock); #1;
      reset = 1'b0;
      smp_kind = 0;
      bus_read(2'd1, 32'h6, "reset_status");
      bus_read(2'd3, 32'd53, "reset_div");

      cyc(4);
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
